mips_debug_ctrl: RTL and testbench
==================================

Name: mips_debug_ctrl

Overview:
Debug/sequencing controller for the MIPS pipeline, driven by a byte-stream command channel (UART RX/TX side).
- Loads programs into instruction memory through the IF write port.
- Gates pipeline advance with o_enable in step or run mode.
- Dumps PC and the register file through the ID debug read port.
- Sits between the UART and the top-level datapath ports i_write, i_instruction, i_address, i_enable and i_address_read_debug.

Parameters:
NB_ADDR, 32, instruction-memory address width (byte address)
NB_INST, 32, instruction word width
NB_DATA, 32, register-file data width
NB_REG, 5, register index width
NB_BYTE, 8, command channel byte width
MAX_INST, 256, instruction-memory depth in words
HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates a load

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  NB_BYTE  received command/data byte
i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
o_tx_data  out  NB_BYTE  byte to transmit
o_tx_start  out  1  one-cycle pulse, o_tx_data valid
i_tx_done  in  1  one-cycle pulse, transmitter finished previous byte
i_halt  in  1  pipeline has retired HALT_WORD (level)
i_pc  in  NB_ADDR  current PC from pipeline
i_data_read_debug  in  NB_DATA  register-file debug read data (combinational from address)
o_write  out  1  instruction-memory write strobe
o_instruction  out  NB_INST  word to write
o_address  out  NB_ADDR  byte address to write
o_enable  out  1  pipeline advance enable
o_address_read_debug  out  NB_REG  register-file debug read index

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; all outputs 0; byte counter, word counter and halted flag cleared. Reset mid-operation aborts the operation with no partial write or TX completion.
- Commands are accepted only in IDLE; bytes arriving in other states are dropped, except in RUN.
  - 0x4C 'L' load
  - 0x53 'S' step
  - 0x52 'R' run
  - 0x44 'D' dump
  - 0x50 'P' pause, RUN only
  - any other byte: reply 0xEE, stay IDLE.
- LOAD:
  - Collect 4 bytes per word, LSB first.
  - On the 4th byte, hold o_write=1 for exactly one cycle with o_instruction=word and o_address=4*word_count; then increment word_count.
  - A word equal to HALT_WORD is written, then the controller sends 0x4B 'K', clears halted and returns to IDLE.
  - Words beyond MAX_INST are not written (o_write stays 0), but byte collection continues until HALT_WORD.
  - word_count resets to 0 at each 'L'.
- STEP: if halted, reply 0x48 'H' with no enable. Otherwise o_enable=1 for exactly one cycle, then reply 'K'.
- RUN:
  - If halted, reply 'H' immediately.
  - Otherwise o_enable=1 continuously from the cycle after the command until i_halt=1 or 'P' is received.
  - On i_halt: o_enable=0 in the same clock edge, set halted, reply 'H'.
  - On 'P': o_enable=0, reply 'K'.
  - i_halt and 'P' in the same cycle: halt wins, reply 'H'.
- DUMP: sends 132 bytes, then returns to IDLE with no trailing ack.
  - First 4 bytes are i_pc, LSB first, sampled when 'D' is accepted.
  - Then registers 0..31, 4 bytes each, LSB first.
  - Per register: DUMP_ADDR drives o_address_read_debug=r for one cycle; DUMP_LATCH captures i_data_read_debug; DUMP_SEND/DUMP_WAIT send its bytes.
  - o_enable=0 throughout the dump.
- TX handshake:
  - o_tx_start pulses one cycle; o_tx_data is held until i_tx_done.
  - The next o_tx_start is no earlier than the cycle after i_tx_done.
  - i_tx_done outside a pending send is ignored.
- States: IDLE, LOAD_BYTE, LOAD_WRITE, STEP, RUN, DUMP_ADDR, DUMP_LATCH, DUMP_SEND, DUMP_WAIT, REPLY, REPLY_WAIT.
- Counters: byte index 2 bits, wraps 3->0; word_count NB_ADDR-2 bits, saturating; register index 0..31, terminal at 31.

Test Plan:
- Reset low mid-LOAD after 2 bytes -> all outputs 0 next cycle; new 'L' + 4 bytes 0x78,0x56,0x34,0x12 -> one-cycle o_write, o_instruction=0x12345678, o_address=0.
- 'L', 3 words (0x20010005, 0x20020003, 0xFFFFFFFF) -> o_write at addresses 0, 4, 8; TX 0x4B.
- 'S' three times -> three single-cycle o_enable pulses, three 'K' replies.
- 'R', i_halt asserted 10 cycles later -> o_enable high exactly 10 cycles, TX 0x48; following 'S' -> 'H' and no enable.
- 'R' then 'P' and i_halt in the same cycle -> reply 'H' only, halted set.
- Preload reg r=value 0x100+r, i_pc=0x1C; 'D' with delayed i_tx_done -> 132 bytes: 1C 00 00 00, then 00 01 00 00 ... 1F 01 00 00. Unknown byte 0x7A in IDLE -> single 0xEE.

Source files
------------

// File: rtl/mips_debug_ctrl.sv
// Byte-command debug controller for the MIPS pipeline: program load, step/run
// gating of the pipeline enable, and a PC + register-file dump over the TX channel.
module mips_debug_ctrl #(
  parameter int                NB_ADDR   = 32,
  parameter int                NB_INST   = 32,
  parameter int                NB_DATA   = 32,
  parameter int                NB_REG    = 5,
  parameter int                NB_BYTE   = 8,
  parameter int                MAX_INST  = 256,
  parameter logic [NB_INST-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic               i_halt,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  output logic               o_write,
  output logic [NB_INST-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_address,
  output logic               o_enable,
  output logic [NB_REG-1:0]  o_address_read_debug
);

  localparam int NB_WORD = 4 * NB_BYTE;
  localparam int WCW     = NB_ADDR - 2;
  localparam logic [WCW-1:0] MAX_WC = WCW'(MAX_INST);

  localparam logic [NB_BYTE-1:0] CMD_LOAD  = 8'h4C;
  localparam logic [NB_BYTE-1:0] CMD_STEP  = 8'h53;
  localparam logic [NB_BYTE-1:0] CMD_RUN   = 8'h52;
  localparam logic [NB_BYTE-1:0] CMD_DUMP  = 8'h44;
  localparam logic [NB_BYTE-1:0] CMD_PAUSE = 8'h50;
  localparam logic [NB_BYTE-1:0] RPL_OK    = 8'h4B;
  localparam logic [NB_BYTE-1:0] RPL_HALT  = 8'h48;
  localparam logic [NB_BYTE-1:0] RPL_ERR   = 8'hEE;

  typedef enum logic [3:0] {
    IDLE, LOAD_BYTE, LOAD_WRITE, STEP, RUN, DUMP_ADDR, DUMP_LATCH,
    DUMP_SEND, DUMP_WAIT, REPLY, REPLY_WAIT
  } state_t;

  state_t             state, state_next;
  logic [1:0]         byte_idx, byte_idx_next;
  logic [WCW-1:0]     word_count, word_count_next;
  logic               halted, halted_next;
  logic [NB_INST-1:0] word_buf, word_buf_next;
  logic [NB_BYTE-1:0] reply_byte, reply_byte_next;
  logic [NB_REG-1:0]  reg_idx, reg_idx_next;
  logic [NB_WORD-1:0] dump_word, dump_word_next;
  logic               dump_pc, dump_pc_next;
  logic               enable, enable_next;
  logic               tx_start, tx_start_next;
  logic [NB_BYTE-1:0] tx_data, tx_data_next;
  logic [NB_REG-1:0]  rd_addr, rd_addr_next;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      byte_idx   <= '0;
      word_count <= '0;
      halted     <= 1'b0;
      word_buf   <= '0;
      reply_byte <= '0;
      reg_idx    <= '0;
      dump_word  <= '0;
      dump_pc    <= 1'b0;
      enable     <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      rd_addr    <= '0;
    end else begin
      state      <= state_next;
      byte_idx   <= byte_idx_next;
      word_count <= word_count_next;
      halted     <= halted_next;
      word_buf   <= word_buf_next;
      reply_byte <= reply_byte_next;
      reg_idx    <= reg_idx_next;
      dump_word  <= dump_word_next;
      dump_pc    <= dump_pc_next;
      enable     <= enable_next;
      tx_start   <= tx_start_next;
      tx_data    <= tx_data_next;
      rd_addr    <= rd_addr_next;
    end
  end

  always_comb begin
    state_next      = state;
    byte_idx_next   = byte_idx;
    word_count_next = word_count;
    halted_next     = halted;
    word_buf_next   = word_buf;
    reply_byte_next = reply_byte;
    reg_idx_next    = reg_idx;
    dump_word_next  = dump_word;
    dump_pc_next    = dump_pc;
    enable_next     = 1'b0;
    tx_start_next   = 1'b0;
    tx_data_next    = tx_data;
    rd_addr_next    = '0;

    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              word_count_next = '0;
              byte_idx_next   = '0;
              state_next      = LOAD_BYTE;
            end
            CMD_STEP, CMD_RUN: begin
              if (halted) begin
                reply_byte_next = RPL_HALT;
                state_next      = REPLY;
              end else begin
                enable_next = 1'b1;
                state_next  = (i_rx_data == CMD_STEP) ? STEP : RUN;
              end
            end
            CMD_DUMP: begin
              dump_word_next = NB_WORD'(i_pc);
              dump_pc_next   = 1'b1;
              byte_idx_next  = '0;
              reg_idx_next   = '0;
              state_next     = DUMP_SEND;
            end
            default: begin
              reply_byte_next = RPL_ERR;
              state_next      = REPLY;
            end
          endcase
        end
      end

      // Bytes arrive LSB first, so shifting in from the top leaves the word aligned.
      LOAD_BYTE: begin
        if (i_rx_valid) begin
          word_buf_next = {i_rx_data, word_buf[NB_INST-1:NB_BYTE]};
          byte_idx_next = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_next = LOAD_WRITE;
        end
      end

      LOAD_WRITE: begin
        if (word_count != '1) word_count_next = word_count + WCW'(1);
        if (word_buf == HALT_WORD) begin
          halted_next     = 1'b0;
          reply_byte_next = RPL_OK;
          state_next      = REPLY;
        end else begin
          state_next = LOAD_BYTE;
        end
      end

      STEP: begin
        reply_byte_next = RPL_OK;
        state_next      = REPLY;
      end

      // A retiring halt takes priority over a simultaneous pause.
      RUN: begin
        if (i_halt) begin
          halted_next     = 1'b1;
          reply_byte_next = RPL_HALT;
          state_next      = REPLY;
        end else if (i_rx_valid && i_rx_data == CMD_PAUSE) begin
          reply_byte_next = RPL_OK;
          state_next      = REPLY;
        end else begin
          enable_next = 1'b1;
        end
      end

      DUMP_ADDR: begin
        rd_addr_next = reg_idx;
        state_next   = DUMP_LATCH;
      end

      DUMP_LATCH: begin
        dump_word_next = NB_WORD'(i_data_read_debug);
        byte_idx_next  = '0;
        state_next     = DUMP_SEND;
      end

      DUMP_SEND: begin
        tx_start_next = 1'b1;
        tx_data_next  = dump_word[NB_BYTE-1:0];
        state_next    = DUMP_WAIT;
      end

      DUMP_WAIT: begin
        if (i_tx_done) begin
          dump_word_next = dump_word >> NB_BYTE;
          byte_idx_next  = byte_idx + 2'd1;
          if (byte_idx != 2'd3) begin
            state_next = DUMP_SEND;
          end else if (dump_pc) begin
            dump_pc_next = 1'b0;
            state_next   = DUMP_ADDR;
          end else if (reg_idx == '1) begin
            state_next = IDLE;
          end else begin
            reg_idx_next = reg_idx + 1'b1;
            state_next   = DUMP_ADDR;
          end
        end
      end

      REPLY: begin
        tx_start_next = 1'b1;
        tx_data_next  = reply_byte;
        state_next    = REPLY_WAIT;
      end

      REPLY_WAIT: begin
        if (i_tx_done) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign o_write              = (state == LOAD_WRITE) && (word_count < MAX_WC);
  assign o_instruction        = o_write ? word_buf : '0;
  assign o_address            = o_write ? {word_count, 2'b00} : '0;
  assign o_enable             = enable;
  assign o_tx_start           = tx_start;
  assign o_tx_data            = tx_data;
  assign o_address_read_debug = rd_addr;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl: directed command sequence with
// randomized data, delays and TX handshake timing, checked against a behavioural model.
module tb_mips_debug_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int          MAXI = 256;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done = 1'b0;
  logic        i_halt = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_data_read_debug;
  logic        o_write;
  logic [31:0] o_instruction;
  logic [31:0] o_address;
  logic        o_enable;
  logic [4:0]  o_address_read_debug;

  logic [31:0] regfile [32];
  logic [7:0]  tx_q [$];
  logic [63:0] wr_q [$];
  logic [31:0] load_words [$];
  int          en_cnt = 0;
  int          total = 0;
  int          bad = 0;

  mips_debug_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .i_halt(i_halt), .i_pc(i_pc), .i_data_read_debug(i_data_read_debug),
    .o_write(o_write), .o_instruction(o_instruction), .o_address(o_address),
    .o_enable(o_enable), .o_address_read_debug(o_address_read_debug)
  );

  always #5 i_clk = ~i_clk;

  assign i_data_read_debug = regfile[o_address_read_debug];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Record everything the DUT emits, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_write === 1'b1) wr_q.push_back({o_address, o_instruction});
    if (o_tx_start === 1'b1) tx_q.push_back(o_tx_data);
    if (o_enable === 1'b1) en_cnt++;
  end

  // Transmitter model: finishes each byte after a random delay.
  initial begin
    int d;
    logic [7:0] held;
    forever begin
      @(negedge i_clk);
      if (o_tx_start === 1'b1) begin
        held = o_tx_data;
        d = $urandom_range(1, 5);
        repeat (d) begin
          @(negedge i_clk);
          checkOutput("tx_start_while_busy", {31'd0, o_tx_start}, 32'd0);
        end
        checkOutput("tx_data_held", {24'd0, o_tx_data}, {24'd0, held});
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic clear_queues();
    tx_q.delete();
    wr_q.delete();
  endtask

  function automatic logic [31:0] tx_at(input int i);
    return (tx_q.size() > i) ? {24'd0, tx_q[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic wait_tx(input int n, input int budget);
    int c = 0;
    while (tx_q.size() < n && c < budget) begin
      @(negedge i_clk);
      c++;
    end
    checkOutput("tx_bytes_arrived", {31'd0, tx_q.size() >= n}, 32'd1);
    idle(10);
  endtask

  // Model: word i lands at byte address 4*i if i < MAX_INST; the halt word ends the load.
  task automatic do_load(input string tag);
    int n_exp = 0;
    logic [63:0] got;
    clear_queues();
    applyStimulus(8'h4C);
    idle(2);
    foreach (load_words[i]) begin
      for (int b = 0; b < 4; b++) begin
        applyStimulus(8'(load_words[i] >> (8 * b)));
        idle(2);
      end
    end
    wait_tx(1, 200);
    checkOutput({tag, "_ack_count"}, tx_q.size(), 1);
    checkOutput({tag, "_ack"}, tx_at(0), 32'h4B);
    foreach (load_words[i]) begin
      if (i < MAXI) n_exp++;
      if (load_words[i] == HALT) break;
    end
    checkOutput({tag, "_write_count"}, wr_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
      got = wr_q[i];
      checkOutput({tag, "_addr"}, got[63:32], 32'(4 * i));
      checkOutput({tag, "_inst"}, got[31:0], load_words[i]);
    end
  endtask

  task automatic expect_reply(input string tag, input logic [7:0] b, input int en_exp, input int en0);
    wait_tx(1, 200);
    checkOutput({tag, "_reply_count"}, tx_q.size(), 1);
    checkOutput({tag, "_reply"}, tx_at(0), {24'd0, b});
    checkOutput({tag, "_enable_cycles"}, en_cnt - en0, en_exp);
  endtask

  task automatic run_halt(input int d);
    int en0;
    clear_queues();
    en0 = en_cnt;
    applyStimulus(8'h52);
    repeat (d - 1) @(negedge i_clk);
    i_halt = 1'b1;
    expect_reply("run_halt", 8'h48, d, en0);
    i_halt = 1'b0;
  endtask

  task automatic run_pause(input int d);
    int en0;
    clear_queues();
    en0 = en_cnt;
    applyStimulus(8'h52);
    repeat (d - 1) @(negedge i_clk);
    applyStimulus(8'h50);
    expect_reply("run_pause", 8'h4B, d, en0);
  endtask

  task automatic single_cmd(input string tag, input logic [7:0] cmd, input logic [7:0] rep, input int en_exp);
    int en0;
    clear_queues();
    en0 = en_cnt;
    applyStimulus(cmd);
    expect_reply(tag, rep, en_exp, en0);
  endtask

  initial begin
    int en0;
    logic [7:0]  ub;
    logic [31:0] w;

    for (int r = 0; r < 32; r++) regfile[r] = 32'h100 + r;

    @(negedge i_clk);
    checkOutput("rst_write", {31'd0, o_write}, 0);
    checkOutput("rst_inst", o_instruction, 0);
    checkOutput("rst_addr", o_address, 0);
    checkOutput("rst_enable", {31'd0, o_enable}, 0);
    checkOutput("rst_tx_start", {31'd0, o_tx_start}, 0);
    checkOutput("rst_tx_data", {24'd0, o_tx_data}, 0);
    checkOutput("rst_rd_addr", {27'd0, o_address_read_debug}, 0);
    i_reset = 1'b1;
    idle(2);

    $display("[TB] reset in the middle of a load");
    applyStimulus(8'h4C); idle(2);
    applyStimulus(8'hAA); idle(2);
    applyStimulus(8'hBB); idle(1);
    #2 i_reset = 1'b0;
    @(negedge i_clk);
    checkOutput("midrst_write", {31'd0, o_write}, 0);
    checkOutput("midrst_inst", o_instruction, 0);
    checkOutput("midrst_tx_start", {31'd0, o_tx_start}, 0);
    i_reset = 1'b1;
    idle(2);
    load_words = '{32'h1234_5678, HALT};
    do_load("load_after_reset");

    $display("[TB] fixed and random program loads");
    load_words = '{32'h2001_0005, 32'h2002_0003, HALT};
    do_load("load_fixed");
    load_words.delete();
    for (int i = 0; i < int'($urandom_range(3, 6)); i++) begin
      w = $urandom();
      if (w == HALT) w = 32'h0;
      load_words.push_back(w);
    end
    load_words.push_back(HALT);
    do_load("load_random");

    $display("[TB] single steps");
    for (int i = 0; i < 3; i++) single_cmd("step", 8'h53, 8'h4B, 1);

    $display("[TB] run until halt, then commands while halted");
    run_halt(10);
    single_cmd("step_halted", 8'h53, 8'h48, 0);
    single_cmd("run_halted", 8'h52, 8'h48, 0);

    load_words = '{HALT};
    do_load("unhalt1");
    run_pause(int'($urandom_range(2, 12)));

    $display("[TB] pause and halt together");
    clear_queues();
    en0 = en_cnt;
    applyStimulus(8'h52);
    repeat (3) @(negedge i_clk);
    i_halt = 1'b1;
    applyStimulus(8'h50);
    expect_reply("pause_halt_tie", 8'h48, 4, en0);
    i_halt = 1'b0;
    single_cmd("step_after_tie", 8'h53, 8'h48, 0);

    load_words = '{HALT};
    do_load("unhalt2");
    run_halt(int'($urandom_range(1, 20)));

    $display("[TB] load past instruction-memory depth");
    load_words.delete();
    for (int i = 0; i < MAXI + 2; i++) begin
      w = $urandom();
      if (w == HALT) w = 32'h1;
      load_words.push_back(w);
    end
    load_words.push_back(HALT);
    do_load("load_overflow");

    $display("[TB] register dump");
    i_pc = 32'h0000_001C;
    clear_queues();
    en0 = en_cnt;
    applyStimulus(8'h44);
    i_pc = 32'h0BAD_0000;
    wait_tx(132, 5000);
    idle(20);
    checkOutput("dump_count", tx_q.size(), 132);
    checkOutput("dump_enable", en_cnt - en0, 0);
    for (int k = 0; k < 132; k++) begin
      w = (k < 4) ? 32'h1C : regfile[(k - 4) / 4];
      checkOutput("dump_byte", tx_at(k), (w >> (8 * (k % 4))) & 32'hFF);
    end

    $display("[TB] unknown commands");
    single_cmd("unknown_7A", 8'h7A, 8'hEE, 0);
    for (int i = 0; i < 3; i++) begin
      ub = 8'($urandom_range(0, 255));
      while (ub == 8'h4C || ub == 8'h53 || ub == 8'h52 || ub == 8'h44 || ub == 8'h50) ub = ub + 8'd1;
      single_cmd("unknown_rand", ub, 8'hEE, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
